// File: rtl/param_seq_source.sv
// rtl/param_seq_source.sv - parameter-defined finite word sequence over a valid/ready stream
// Three-state FSM (IDLE/RUN/DONE); outputs decode from registered state only, so out_ready never reaches out_valid/out_data.
module param_seq_source #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] START_VALUE = 32'h12,
  parameter logic [31:0] STEP        = 32'h1,
  parameter int          LENGTH      = 16,
  parameter bit          WRAP_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      seq_count
);

  localparam logic [WIDTH-1:0] START_W  = START_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP_W   = STEP[WIDTH-1:0];
  localparam logic [15:0]      LAST_IDX = 16'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     index;
  logic [WIDTH:0]  sum;
  logic [WIDTH-1:0] next_word;
  logic            handshake;
  logic            is_last;

  // Carry out of the WIDTH+1 bit sum selects all-ones when saturating.
  assign sum       = {1'b0, out_data} + {1'b0, STEP_W};
  assign next_word = (WRAP_EN || !sum[WIDTH]) ? sum[WIDTH-1:0] : {WIDTH{1'b1}};
  assign is_last   = (index == LAST_IDX);
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = is_last;
        busy      = 1'b1;
        if (handshake && is_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      index     <= '0;
      seq_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        out_data <= START_W;
        index    <= '0;
      end else if (state == RUN && handshake && !is_last) begin
        out_data <= next_word;
        index    <= index + 16'd1;
      end
      if (state == DONE) seq_count <= seq_count + 16'd1;
    end
  end

endmodule
